mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single backing-memory port between three requesters: I-cache refill (read, port 0),
//  D-cache refill (read, port 1) and store-buffer drain (write, port 2). Sits between the fetch and
//  memory stages and the backing RAM. Serialises one word-transaction at a time with a fixed
//  access latency and round-robin fairness.
// PARAMETERS
//  MEM_LATENCY  4   cycles mem_addr/mem_we are held before data is sampled (>=1)
//  ADDR_W       32  address width
//  DATA_W       32  data width
// PORTS
//  clk         in   1       clock, rising edge
//  reset       in   1       asynchronous, active-low reset
//  req         in   3       per-port request; held high, with stable addr/wdata, until done
//  addr0..2    in   ADDR_W  per-port word address
//  wdata2      in   DATA_W  store-buffer write data (port 2 only writes)
//  grant       out  3       one-hot, high for the whole transaction of the granted port
//  done        out  3       one-hot, 1-cycle pulse when the transaction completes
//  rdata       out  DATA_W  read data, valid in the done cycle for port 0/1
//  mem_req     out  1       memory access active
//  mem_we      out  1       write strobe (port 2 transaction)
//  mem_addr    out  ADDR_W  memory address
//  mem_wdata   out  DATA_W  memory write data
//  mem_rdata   in   DATA_W  memory read data (combinational from mem_addr)
//  busy        out  1       FSM not in IDLE
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE, rr_ptr=0, grant=0, done=0, rdata=0, mem_req=0, mem_we=0,
//   mem_addr=0, mem_wdata=0, busy=0, count=0. Reset mid-transaction aborts it; no done pulse.
//  FSM IDLE -> ACCESS -> RESP -> IDLE.
//   IDLE: if |req, pick winner by round-robin starting at rr_ptr (order rr_ptr, rr_ptr+1, ... mod 3);
//    register grant, mem_addr, mem_we (=winner==2), mem_wdata; count=MEM_LATENCY-1; go ACCESS.
//    No req: stay IDLE, outputs unchanged except done=0.
//   ACCESS: mem_req=1; count decrements each cycle; when count==0 sample mem_rdata into rdata
//    (reads only; writes leave rdata unchanged) and go RESP. Memory held exactly MEM_LATENCY cycles.
//   RESP: done[winner]=1 for one cycle, grant cleared, mem_req=0, mem_we=0;
//    rr_ptr=(winner+1) mod 3 (wrap 2->0); go IDLE.
//  Latency: req rising in IDLE -> done pulse MEM_LATENCY+2 cycles later. Max one transaction in
//   flight; minimum back-to-back spacing MEM_LATENCY+2 cycles (IDLE arbitration cycle always taken).
//  Simultaneous requests: exactly one grant; others wait; every continuously asserted req is
//   served within 3 transactions (no starvation).
//  Request dropped while granted: transaction completes anyway, done still pulses; inputs are
//   latched at grant, so addr/wdata changes after grant are ignored.
//  req already high during RESP is not granted until the following IDLE cycle.
//  grant is never asserted for a port whose req was low in the arbitration cycle.
// CONFIGURATION
//  MEM_ARB_STATS_EN defined: adds outputs stat_grants0..2 (32b, count completed transactions per
//   port) and stat_wait (32b, counts cycles where some req is high and that port is not granted);
//   all reset to 0 and saturate at all-ones.
//  Not defined: ports and counters absent; functional behaviour identical.
// STRUCTURE
//  Shared package mem_arb_pkg: state encoding (ST_IDLE, ST_ACCESS, ST_RESP), port indices
//   (PORT_IC=0, PORT_DC=1, PORT_SB=2), NUM_PORTS=3.
//  One sub-module rr_picker (combinational: req[2:0], rr_ptr -> one-hot winner, any).
//  FSM, latency counter and output registers live in mem_port_arbiter.
// TESTING
//  Reset: hold reset=0 with req=3'b111 -> all outputs 0, no grant; release -> grant 3'b001 next cycle.
//  Single read: req=001, addr0=0x40, mem_rdata=0xDEADBEEF, MEM_LATENCY=4 -> done=001 at cycle 6, rdata=0xDEADBEEF.
//  Write: req=100, addr2=0x80, wdata2=0x12345678 -> mem_we=1, mem_addr=0x80 for 4 cycles; done=100; rdata unchanged.
//  Fairness: req=111 held -> grant order 001,010,100,001; rr_ptr wraps 2->0.
//  Drop/reset: drop req0 mid-ACCESS -> done0 still pulses; assert reset mid-ACCESS -> immediate IDLE, no done.
//  Stats (MEM_ARB_STATS_EN): after fairness run of 4 transactions -> stat_grants0=2, stat_grants1=1, stat_grants2=1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, port indices and round-robin helper for mem_port_arbiter
package mem_arb_pkg;
  localparam int NUM_PORTS = 3;
  localparam int PORT_IC = 0;
  localparam int PORT_DC = 1;
  localparam int PORT_SB = 2;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;
  function automatic logic [1:0] next_ptr(input logic [NUM_PORTS-1:0] g);
    return g[PORT_IC] ? 2'd1 : g[PORT_DC] ? 2'd2 : 2'd0;
  endfunction
endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick among three requesters starting at rr_ptr_i
module rr_picker
  import mem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [1:0]           rr_ptr_i,
  output logic [NUM_PORTS-1:0] winner_o,
  output logic                 any_o
);
  logic [NUM_PORTS-1:0] rot, pick;
  // rotate so bit 0 is the highest-priority port, fixed-priority pick, then rotate back
  always_comb begin
    rot      = rr_ptr_i == 2'd1 ? {req_i[0], req_i[2], req_i[1]} :
               rr_ptr_i == 2'd2 ? {req_i[1], req_i[0], req_i[2]} : req_i;
    pick     = rot[0] ? 3'b001 : rot[1] ? 3'b010 : rot[2] ? 3'b100 : 3'b000;
    winner_o = rr_ptr_i == 2'd1 ? {pick[1], pick[0], pick[2]} :
               rr_ptr_i == 2'd2 ? {pick[0], pick[2], pick[1]} : pick;
    any_o    = |req_i;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of one memory port by IC/DC/SB; MEM_ARB_STATS_EN adds stat counters
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req,
  input  logic [ADDR_W-1:0]    addr0,
  input  logic [ADDR_W-1:0]    addr1,
  input  logic [ADDR_W-1:0]    addr2,
  input  logic [DATA_W-1:0]    wdata2,
  output logic [NUM_PORTS-1:0] grant,
  output logic [NUM_PORTS-1:0] done,
  output logic [DATA_W-1:0]    rdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic                 busy
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]          stat_grants0,
  output logic [31:0]          stat_grants1,
  output logic [31:0]          stat_grants2,
  output logic [31:0]          stat_wait
`endif
);
  localparam int CW = $clog2(MEM_LATENCY + 1);
  state_t               state_q, state_d;
  logic [1:0]           rr_q, rr_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d, done_q, done_d, win;
  logic                 any;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 mreq_q, mreq_d, we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d, rdata_q, rdata_d;

  rr_picker u_pick (.req_i(req), .rr_ptr_i(rr_q), .winner_o(win), .any_o(any));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q == ST_IDLE   ? (any ? ST_ACCESS : ST_IDLE) :
              state_q == ST_ACCESS ? (cnt_q == '0 ? ST_RESP : ST_ACCESS) : ST_IDLE;
  end

  always_comb begin
    grant_d = grant_q;
    done_d  = '0;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    mreq_d  = mreq_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: if (any) begin
        grant_d = win;
        addr_d  = win[PORT_IC] ? addr0 : win[PORT_DC] ? addr1 : addr2;
        we_d    = win[PORT_SB];
        wdata_d = wdata2;
        cnt_d   = CW'(MEM_LATENCY - 1);
        mreq_d  = 1'b1;
      end
      ST_ACCESS: begin
        cnt_d = cnt_q == '0 ? cnt_q : cnt_q - CW'(1);
        if (cnt_q == '0) begin
          mreq_d  = 1'b0;
          we_d    = 1'b0;
          rdata_d = we_q ? rdata_q : mem_rdata;
        end
      end
      ST_RESP: begin
        done_d  = grant_q;
        grant_d = '0;
        rr_d    = next_ptr(grant_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_q <= '0;
      done_q  <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      mreq_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      grant_q <= grant_d;
      done_q  <= done_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      mreq_q  <= mreq_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign mem_req   = mreq_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = state_q != ST_IDLE;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] sg_q [NUM_PORTS];
  logic [31:0] sw_q;
  // saturating counters: completions per port, and cycles with any un-granted request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PORTS; i++) sg_q[i] <= '0;
      sw_q <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++)
        if (state_q == ST_RESP && grant_q[i] && !(&sg_q[i])) sg_q[i] <= sg_q[i] + 32'd1;
      if (|(req & ~grant_q) && !(&sw_q)) sw_q <= sw_q + 32'd1;
    end
  end
  assign stat_grants0 = sg_q[PORT_IC];
  assign stat_grants1 = sg_q[PORT_DC];
  assign stat_grants2 = sg_q[PORT_SB];
  assign stat_wait    = sw_q;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with a transaction-level round-robin model of the arbiter
module tb_mem_port_arbiter;
  localparam int LAT = 4;
  logic        clk = 1'b0, reset = 1'b0;
  logic [2:0]  req = '0;
  logic [31:0] addr0 = '0, addr1 = '0, addr2 = '0, wdata2 = '0;
  logic [2:0]  grant, done;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_req, mem_we, busy;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_grants0, stat_grants1, stat_grants2, stat_wait;
`endif

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return a == 32'h40 ? 32'hDEADBEEF : (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction
  assign mem_rdata = mem_model(mem_addr);

  mem_port_arbiter #(.MEM_LATENCY(LAT), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .req(req), .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .wdata2(wdata2), .grant(grant), .done(done), .rdata(rdata), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
`ifdef MEM_ARB_STATS_EN
    , .stat_grants0(stat_grants0), .stat_grants1(stat_grants1),
    .stat_grants2(stat_grants2), .stat_wait(stat_wait)
`endif
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          port;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    bit          we;
    int          cyc;
  } exp_t;
  exp_t        q[$];
  int          n_cmp = 0, n_bad = 0;
  int          ptr_m = 0;
  logic [31:0] last_rd = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // reference: held requests are served one per slot, each slot picking the first pending
  // port at or after the pointer, which then moves just past the served port
  task automatic predict(input int r0, input int r1, input int r2, input int issue);
    int   rm[3];
    int   t;
    int   j;
    exp_t e;
    rm = '{r0, r1, r2};
    t  = 0;
    while (rm[0] + rm[1] + rm[2] > 0) begin
      j = ptr_m;
      while (rm[j] == 0) j = (j + 1) % 3;
      e.port = j;
      e.addr = j == 0 ? addr0 : j == 1 ? addr1 : addr2;
      e.we   = j == 2;
      e.data = wdata2;
      if (!e.we) last_rd = mem_model(e.addr);
      e.rdata = last_rd;
      t++;
      e.cyc = issue + t * (LAT + 2);
      q.push_back(e);
      rm[j]--;
      ptr_m = (j + 1) % 3;
    end
  endtask

  int          mq_cnt = 0, we_cnt = 0;
  logic [31:0] cap_addr = '0, cap_wdata = '0;
  logic [2:0]  g_exp;
  exp_t        m;
  always @(negedge clk) begin
    if (!reset) begin
      mq_cnt = 0;
      we_cnt = 0;
    end else begin
      if (mem_req) begin
        mq_cnt++;
        if (mem_we) we_cnt++;
        cap_addr  = mem_addr;
        cap_wdata = mem_wdata;
      end
      if (grant != 3'b000 && q.size() > 0) begin
        g_exp = 3'b001 << q[0].port;
        chk("grant", grant, g_exp);
      end
      if (done != 3'b000) begin
        if (q.size() == 0) chk("done_unexpected", done, 0);
        else begin
          m = q.pop_front();
          g_exp = 3'b001 << m.port;
          chk("done_port", done, g_exp);
          chk("done_cycle", cyc, m.cyc);
          chk("rdata", rdata, m.rdata);
          chk("mem_req_cycles", mq_cnt, LAT);
          chk("mem_we_cycles", we_cnt, m.we ? LAT : 0);
          chk("mem_addr", cap_addr, m.addr);
          if (m.we) chk("mem_wdata", cap_wdata, m.data);
        end
        mq_cnt = 0;
        we_cnt = 0;
      end
    end
  end

  task automatic scramble(input int i);
    if (i == 0) addr0 = $urandom;
    else if (i == 1) addr1 = $urandom;
    else begin
      addr2  = $urandom;
      wdata2 = $urandom;
    end
  endtask

  task automatic run_round(input int r0, input int r1, input int r2, input bit rnd);
    int rem[3];
    int budget;
    rem = '{r0, r1, r2};
    if (rnd) begin
      addr0  = $urandom;
      addr1  = $urandom;
      addr2  = $urandom;
      wdata2 = $urandom;
    end
    predict(r0, r1, r2, cyc);
    req    = {rem[2] > 0, rem[1] > 0, rem[0] > 0};
    budget = (r0 + r1 + r2) * (LAT + 2) + 10;
    while (rem[0] + rem[1] + rem[2] > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
      for (int i = 0; i < 3; i++)
        if (done[i] && rem[i] > 0) begin
          rem[i]--;
          if (rem[i] == 0) req[i] = 1'b0;
        end
      if (rnd)
        for (int i = 0; i < 3; i++)
          if (grant[i] && rem[i] == 1) begin
            scramble(i);
            if ($urandom_range(0, 3) == 0) req[i] = 1'b0;
          end
    end
    if (rem[0] + rem[1] + rem[2] > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL round_timeout: %0d transactions still pending, required 0", rem[0] + rem[1] + rem[2]);
      req = '0;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int r[3];
`ifdef MEM_ARB_STATS_EN
    logic [31:0] s0, s1, s2;
`endif
    req = 3'b111;
    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    run_round(1, 1, 1, 1'b1);
    addr0 = 32'h40;
    run_round(1, 0, 0, 1'b0);
    addr2  = 32'h80;
    wdata2 = 32'h12345678;
    run_round(0, 0, 1, 1'b0);
`ifdef MEM_ARB_STATS_EN
    s0 = stat_grants0;
    s1 = stat_grants1;
    s2 = stat_grants2;
`endif
    run_round(2, 1, 1, 1'b0);
`ifdef MEM_ARB_STATS_EN
    chk("stat_grants0", stat_grants0 - s0, 2);
    chk("stat_grants1", stat_grants1 - s1, 1);
    chk("stat_grants2", stat_grants2 - s2, 1);
`endif
    addr0 = $urandom;
    req   = 3'b001;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", busy, 1);
    reset = 1'b0;
    #1;
    chk("abort_grant", grant, 0);
    chk("abort_busy", busy, 0);
    chk("abort_mem_req", mem_req, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    reset   = 1'b1;
    req     = '0;
    ptr_m   = 0;
    last_rd = '0;
    repeat (10) @(negedge clk);
    for (int n = 0; n < 30; n++) begin
      r[0] = $urandom_range(0, 2);
      r[1] = $urandom_range(0, 2);
      r[2] = $urandom_range(0, 2);
      if (r[0] + r[1] + r[2] == 0) r[$urandom_range(0, 2)] = 1;
      run_round(r[0], r[1], r[2], 1'b1);
    end
    repeat (8) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
